// File: rtl/max7219_display_ctrl.sv
// Command sequencer feeding the MAX7219 SPI driver: init writes after reset, then digit refreshes.
// Optional build macro MAX7219_COLON_BLINK_EN drives the DP of digits 3 and 5 from the seconds LSB.
module max7219_display_ctrl #(
  parameter int NUM_DIGITS = 6
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_update,
  input  logic [7:0] i_hours,
  input  logic [7:0] i_minutes,
  input  logic [7:0] i_seconds,
  input  logic [3:0] i_intensity,
  input  logic       i_drv_busy,
  input  logic       i_drv_ack,
  output logic       o_drv_stb,
  output logic [3:0] o_drv_addr,
  output logic [7:0] o_drv_data,
  output logic       o_init_done,
  output logic       o_refresh_busy
);

  // state      | meaning
  // INIT_SEND  | strobe init command idx when the driver is free
  // INIT_WAIT  | wait for driver ack of the init command
  // IDLE       | display up to date, waiting for i_update
  // REF_SEND   | strobe refresh command (idx 0 = intensity, 1..N = digits)
  // REF_WAIT   | wait for driver ack of the refresh command
  localparam logic [2:0] S_INIT_SEND = 3'd0;
  localparam logic [2:0] S_INIT_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_REF_SEND  = 3'd3;
  localparam logic [2:0] S_REF_WAIT  = 3'd4;

  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS);
  localparam logic [7:0] SCAN_LIMIT = 8'(NUM_DIGITS - 1);
  localparam logic [3:0] LAST_INIT  = 4'd4;

  logic [2:0] state;
  logic [3:0] idx;
  logic       pending;
  logic [7:0] snap_h;
  logic [7:0] snap_m;
  logic [7:0] snap_s;
  logic [3:0] last_int;

  logic [3:0] init_addr;
  logic [7:0] init_data;
  logic [3:0] ref_idx;
  logic [3:0] ref_addr;
  logic [7:0] ref_data;
  logic [3:0] nibble;
  logic       dp;

  always_comb begin
    init_addr = 4'hC;
    init_data = 8'h01;
    case (idx)
      4'd0: begin init_addr = 4'hF; init_data = 8'h00; end
      4'd1: begin init_addr = 4'h9; init_data = 8'hFF; end
      4'd2: begin init_addr = 4'hB; init_data = SCAN_LIMIT; end
      4'd3: begin init_addr = 4'hA; init_data = {4'h0, i_intensity}; end
      default: begin init_addr = 4'hC; init_data = 8'h01; end
    endcase
  end

  // An unchanged intensity skips straight to digit 1 without spending a cycle.
  assign ref_idx = (idx == 4'd0 && i_intensity == last_int) ? 4'd1 : idx;

  always_comb begin
    nibble = 4'hF;
    case (ref_idx)
      4'd1: nibble = snap_s[3:0];
      4'd2: nibble = snap_s[7:4];
      4'd3: nibble = snap_m[3:0];
      4'd4: nibble = snap_m[7:4];
      4'd5: nibble = snap_h[3:0];
      4'd6: nibble = snap_h[7:4];
      default: nibble = 4'hF;
    endcase
  end

`ifdef MAX7219_COLON_BLINK_EN
  assign dp = snap_s[0] && (ref_idx == 4'd3 || ref_idx == 4'd5);
`else
  assign dp = 1'b0;
`endif

  assign ref_addr = (ref_idx == 4'd0) ? 4'hA : ref_idx;
  assign ref_data = (ref_idx == 4'd0) ? {4'h0, i_intensity} : {dp, 3'b000, nibble};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= S_INIT_SEND;
      idx            <= 4'd0;
      pending        <= 1'b0;
      snap_h         <= 8'h00;
      snap_m         <= 8'h00;
      snap_s         <= 8'h00;
      last_int       <= 4'h0;
      o_drv_stb      <= 1'b0;
      o_drv_addr     <= 4'h0;
      o_drv_data     <= 8'h00;
      o_init_done    <= 1'b0;
      o_refresh_busy <= 1'b0;
    end else begin
      o_drv_stb      <= 1'b0;
      o_refresh_busy <= 1'b1;
      if (i_update && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_INIT_SEND: begin
          if (!i_drv_busy) begin
            o_drv_stb  <= 1'b1;
            o_drv_addr <= init_addr;
            o_drv_data <= init_data;
            if (idx == 4'd3) last_int <= i_intensity;
            state <= S_INIT_WAIT;
          end
        end
        S_INIT_WAIT: begin
          if (i_drv_ack) begin
            if (idx == LAST_INIT) begin
              // The first refresh is automatic, so requests seen during init are already covered.
              o_init_done <= 1'b1;
              pending     <= 1'b0;
              snap_h      <= i_hours;
              snap_m      <= i_minutes;
              snap_s      <= i_seconds;
              idx         <= 4'd0;
              state       <= S_REF_SEND;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_INIT_SEND;
            end
          end
        end
        S_IDLE: begin
          if (i_update) begin
            snap_h <= i_hours;
            snap_m <= i_minutes;
            snap_s <= i_seconds;
            idx    <= 4'd0;
            state  <= S_REF_SEND;
          end else begin
            o_refresh_busy <= 1'b0;
          end
        end
        S_REF_SEND: begin
          if (!i_drv_busy) begin
            o_drv_stb  <= 1'b1;
            o_drv_addr <= ref_addr;
            o_drv_data <= ref_data;
            idx        <= ref_idx;
            if (ref_idx == 4'd0) last_int <= i_intensity;
            state <= S_REF_WAIT;
          end
        end
        S_REF_WAIT: begin
          if (i_drv_ack) begin
            if (idx == LAST_DIGIT) begin
              if (pending || i_update) begin
                pending <= 1'b0;
                snap_h  <= i_hours;
                snap_m  <= i_minutes;
                snap_s  <= i_seconds;
                idx     <= 4'd0;
                state   <= S_REF_SEND;
              end else begin
                o_refresh_busy <= 1'b0;
                state          <= S_IDLE;
              end
            end else begin
              idx   <= idx + 4'd1;
              state <= S_REF_SEND;
            end
          end
        end
        default: begin
          idx   <= 4'd0;
          state <= S_INIT_SEND;
        end
      endcase
    end
  end

endmodule
